// File: rtl/spu_pkg.sv
// -----------------------------------------------------------------------------
// spu_pkg
// Shared definitions for the SPU pipes: register file geometry, nop encodings
// and the decoded-instruction bundle handed to operand fetch.
// -----------------------------------------------------------------------------
package spu_pkg;

  localparam int REG_ADDR_W = 7;
  localparam int WIDTH      = 128;

  localparam logic [0:10] NOP_OP     = 11'b0;
  localparam logic [2:0]  NOP_FORMAT = 3'd0;

  // One decoded instruction as presented to register fetch.
  typedef struct packed {
    logic [0:10]           op;
    logic [2:0]            format;
    logic [0:REG_ADDR_W-1] ra_addr;
    logic [0:REG_ADDR_W-1] rb_addr;
    logic [0:REG_ADDR_W-1] rt_addr;
    logic [0:17]           imm;
    logic                  reg_write;
    logic                  use_ra;
    logic                  use_rb;
    logic                  use_rt;
  } dec_instr_t;

endpackage

// File: rtl/odd_rf_fwd_register_file.sv
// -----------------------------------------------------------------------------
// register_file
// NUM_REGS x WIDTH register file with two write ports (even, odd) and three
// combinational read ports. Reads see same-cycle writebacks through a bypass.
// The odd port wins both for the array write and for the bypass when both
// ports target the same address. reset clears every entry in one edge and
// drops any writeback presented in that cycle.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   we_e/addr_e/data_e          even-pipe writeback
//   we_o/addr_o/data_o          odd-pipe writeback (priority)
//   rd_a/b/c_addr -> rd_a/b/c_data   bypassed combinational reads
// -----------------------------------------------------------------------------
module register_file
  import spu_pkg::*;
#(
  parameter int NUM_REGS = 128,
  parameter int WIDTH    = spu_pkg::WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we_e,
  input  logic [0:REG_ADDR_W-1] addr_e,
  input  logic [WIDTH-1:0]      data_e,
  input  logic                  we_o,
  input  logic [0:REG_ADDR_W-1] addr_o,
  input  logic [WIDTH-1:0]      data_o,
  input  logic [0:REG_ADDR_W-1] rd_a_addr,
  input  logic [0:REG_ADDR_W-1] rd_b_addr,
  input  logic [0:REG_ADDR_W-1] rd_c_addr,
  output logic [WIDTH-1:0]      rd_a_data,
  output logic [WIDTH-1:0]      rd_b_data,
  output logic [WIDTH-1:0]      rd_c_data
);

  logic [WIDTH-1:0] mem_q [NUM_REGS];
  logic [WIDTH-1:0] mem_d [NUM_REGS];

  // Odd write applied after even so it overrides on an address collision.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_d[i] = '0;
      end
    end else begin
      if (we_e) mem_d[addr_e] = data_e;
      if (we_o) mem_d[addr_o] = data_o;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  function automatic logic [WIDTH-1:0] read_byp(input logic [0:REG_ADDR_W-1] addr,
                                                input logic [WIDTH-1:0] arr_val);
    if (we_o && (addr_o == addr))      return data_o;
    else if (we_e && (addr_e == addr)) return data_e;
    else                               return arr_val;
  endfunction

  assign rd_a_data = read_byp(rd_a_addr, mem_q[rd_a_addr]);
  assign rd_b_data = read_byp(rd_b_addr, mem_q[rd_b_addr]);
  assign rd_c_data = read_byp(rd_c_addr, mem_q[rd_c_addr]);

endmodule

// File: rtl/odd_rf_fwd.sv
// -----------------------------------------------------------------------------
// odd_rf_fwd
// Register-fetch / forwarding stage of the odd pipe. Reads up to three
// operands per cycle from the register file (with writeback bypass), checks
// used sources against in-flight destinations, and registers operands plus
// control for the local-store stage. A hazard, flush, reset or empty slot
// loads a nop into the output register.
//
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   in_valid, in_op, in_format,        decoded instruction
//   in_ra/rb/rt_addr, in_imm,
//   in_reg_write, in_use_ra/rb/rt
//   flush                              kill the instruction being registered
//   wb_e_*, wb_o_*                     even / odd writebacks
//   pend_addr, pend_we                 in-flight destinations
//   op, format, rt_addr, imm,          registered control (1-cycle latency)
//   reg_write
//   ra, rb, rt_st                      registered operands
//   stall                              combinational hold request
// -----------------------------------------------------------------------------
module odd_rf_fwd
  import spu_pkg::*;
#(
  parameter int NUM_REGS = 128,
  parameter int WIDTH    = spu_pkg::WIDTH,
  parameter int DEPTH    = 6
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                in_valid,
  input  logic [0:10]                         in_op,
  input  logic [2:0]                          in_format,
  input  logic [0:REG_ADDR_W-1]               in_ra_addr,
  input  logic [0:REG_ADDR_W-1]               in_rb_addr,
  input  logic [0:REG_ADDR_W-1]               in_rt_addr,
  input  logic [0:17]                         in_imm,
  input  logic                                in_reg_write,
  input  logic                                in_use_ra,
  input  logic                                in_use_rb,
  input  logic                                in_use_rt,
  input  logic                                flush,
  input  logic [WIDTH-1:0]                    wb_e_data,
  input  logic [0:REG_ADDR_W-1]               wb_e_addr,
  input  logic                                wb_e_we,
  input  logic [WIDTH-1:0]                    wb_o_data,
  input  logic [0:REG_ADDR_W-1]               wb_o_addr,
  input  logic                                wb_o_we,
  input  logic [DEPTH-1:0][0:REG_ADDR_W-1]    pend_addr,
  input  logic [DEPTH-1:0]                    pend_we,
  output logic [0:10]                         op,
  output logic [2:0]                          format,
  output logic [0:REG_ADDR_W-1]               rt_addr,
  output logic [0:17]                         imm,
  output logic                                reg_write,
  output logic [WIDTH-1:0]                    ra,
  output logic [WIDTH-1:0]                    rb,
  output logic [WIDTH-1:0]                    rt_st,
  output logic                                stall
);

  dec_instr_t in_instr;

  assign in_instr = '{op:        in_op,
                      format:    in_format,
                      ra_addr:   in_ra_addr,
                      rb_addr:   in_rb_addr,
                      rt_addr:   in_rt_addr,
                      imm:       in_imm,
                      reg_write: in_reg_write,
                      use_ra:    in_use_ra,
                      use_rb:    in_use_rb,
                      use_rt:    in_use_rt};

  logic [WIDTH-1:0] rd_ra, rd_rb, rd_rt;

  register_file #(
    .NUM_REGS (NUM_REGS),
    .WIDTH    (WIDTH)
  ) u_register_file (
    .clk       (clk),
    .reset     (reset),
    .we_e      (wb_e_we),
    .addr_e    (wb_e_addr),
    .data_e    (wb_e_data),
    .we_o      (wb_o_we),
    .addr_o    (wb_o_addr),
    .data_o    (wb_o_data),
    .rd_a_addr (in_instr.ra_addr),
    .rd_b_addr (in_instr.rb_addr),
    .rd_c_addr (in_instr.rt_addr),
    .rd_a_data (rd_ra),
    .rd_b_data (rd_rb),
    .rd_c_data (rd_rt)
  );

  // Hazard compare: only sources that are actually read can stall. A
  // same-cycle writeback does not clear it; the pend entry must retire first.
  logic hazard;

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (pend_we[i]) begin
        if (in_instr.use_ra && (pend_addr[i] == in_instr.ra_addr)) hazard = 1'b1;
        if (in_instr.use_rb && (pend_addr[i] == in_instr.rb_addr)) hazard = 1'b1;
        if (in_instr.use_rt && (pend_addr[i] == in_instr.rt_addr)) hazard = 1'b1;
      end
    end
  end

  // Flush outranks a hazard; reset forces stall low.
  assign stall = in_valid & hazard & ~flush & ~reset;

  logic load_nop;
  assign load_nop = reset | flush | ~in_valid | stall;

  logic [0:10]           op_d,        op_q;
  logic [2:0]            format_d,    format_q;
  logic [0:REG_ADDR_W-1] rt_addr_d,   rt_addr_q;
  logic [0:17]           imm_d,       imm_q;
  logic                  reg_write_d, reg_write_q;
  logic [WIDTH-1:0]      ra_d,        ra_q;
  logic [WIDTH-1:0]      rb_d,        rb_q;
  logic [WIDTH-1:0]      rt_st_d,     rt_st_q;

  always_comb begin
    op_d        = NOP_OP;
    format_d    = NOP_FORMAT;
    rt_addr_d   = '0;
    imm_d       = '0;
    reg_write_d = 1'b0;
    ra_d        = '0;
    rb_d        = '0;
    rt_st_d     = '0;
    if (!load_nop) begin
      op_d        = in_instr.op;
      format_d    = in_instr.format;
      rt_addr_d   = in_instr.rt_addr;
      imm_d       = in_instr.imm;
      reg_write_d = in_instr.reg_write;
      ra_d        = rd_ra;
      rb_d        = rd_rb;
      rt_st_d     = rd_rt;
    end
  end

  // ---- stage boundary: register fetch -> local store ----
  always_ff @(posedge clk) begin
    op_q        <= op_d;
    format_q    <= format_d;
    rt_addr_q   <= rt_addr_d;
    imm_q       <= imm_d;
    reg_write_q <= reg_write_d;
    ra_q        <= ra_d;
    rb_q        <= rb_d;
    rt_st_q     <= rt_st_d;
  end

  assign op        = op_q;
  assign format    = format_q;
  assign rt_addr   = rt_addr_q;
  assign imm       = imm_q;
  assign reg_write = reg_write_q;
  assign ra        = ra_q;
  assign rb        = rb_q;
  assign rt_st     = rt_st_q;

endmodule

// File: tb/tb_odd_rf_fwd.sv
module tb_odd_rf_fwd;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic [0:10]        in_op;
  logic [2:0]         in_format;
  logic [0:6]         in_ra_addr, in_rb_addr, in_rt_addr;
  logic [0:17]        in_imm;
  logic               in_reg_write, in_use_ra, in_use_rb, in_use_rt;
  logic               flush;
  logic [127:0]       wb_e_data, wb_o_data;
  logic [0:6]         wb_e_addr, wb_o_addr;
  logic               wb_e_we, wb_o_we;
  logic [5:0][0:6]    pend_addr;
  logic [5:0]         pend_we;
  logic [0:10]        op;
  logic [2:0]         format;
  logic [0:6]         rt_addr;
  logic [0:17]        imm;
  logic               reg_write;
  logic [127:0]       ra, rb, rt_st;
  logic               stall;

  odd_rf_fwd dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_op(in_op),
    .in_format(in_format), .in_ra_addr(in_ra_addr), .in_rb_addr(in_rb_addr),
    .in_rt_addr(in_rt_addr), .in_imm(in_imm), .in_reg_write(in_reg_write),
    .in_use_ra(in_use_ra), .in_use_rb(in_use_rb), .in_use_rt(in_use_rt),
    .flush(flush), .wb_e_data(wb_e_data), .wb_e_addr(wb_e_addr),
    .wb_e_we(wb_e_we), .wb_o_data(wb_o_data), .wb_o_addr(wb_o_addr),
    .wb_o_we(wb_o_we), .pend_addr(pend_addr), .pend_we(pend_we),
    .op(op), .format(format), .rt_addr(rt_addr), .imm(imm),
    .reg_write(reg_write), .ra(ra), .rb(rb), .rt_st(rt_st), .stall(stall)
  );

  always #5 clk = ~clk;

  localparam logic [10:0] OP_LQX  = 11'h1C4;
  localparam logic [10:0] OP_STQD = 11'h240;
  localparam logic [10:0] OP_LQD  = 11'h340;
  localparam logic [10:0] OP_STQA = 11'h208;

  typedef struct {
    logic [10:0]  op;
    logic [2:0]   fmt;
    logic [6:0]   rt;
    logic [17:0]  imm;
    logic         rw;
    logic [127:0] ra;
    logic [127:0] rb;
    logic [127:0] rts;
  } exp_t;

  exp_t         sb_q[$];
  logic [127:0] model [128];
  int           errors = 0;
  int           checks = 0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [127:0] mread(input logic [6:0] a);
    if (wb_o_we && wb_o_addr == a) return wb_o_data;
    if (wb_e_we && wb_e_addr == a) return wb_e_data;
    return model[a];
  endfunction

  function automatic logic exp_stall();
    logic hz = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (pend_we[i]) begin
        if (in_use_ra && pend_addr[i] == in_ra_addr) hz = 1'b1;
        if (in_use_rb && pend_addr[i] == in_rb_addr) hz = 1'b1;
        if (in_use_rt && pend_addr[i] == in_rt_addr) hz = 1'b1;
      end
    end
    return in_valid && hz && !flush && !reset;
  endfunction

  // One clock: check stall, push expected output, clock, pop and compare.
  task automatic step(input string tag);
    exp_t e;
    logic st;
    #1;
    st = exp_stall();
    check({tag, ".stall"}, {127'b0, stall}, {127'b0, st});
    e = '{op: '0, fmt: '0, rt: '0, imm: '0, rw: 1'b0, ra: '0, rb: '0, rts: '0};
    if (!(reset || flush || !in_valid || st)) begin
      e.op  = in_op;        e.fmt = in_format;  e.rt  = in_rt_addr;
      e.imm = in_imm;       e.rw  = in_reg_write;
      e.ra  = mread(in_ra_addr);
      e.rb  = mread(in_rb_addr);
      e.rts = mread(in_rt_addr);
    end
    sb_q.push_back(e);
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 128; i++) model[i] = '0;
    end else begin
      if (wb_e_we) model[wb_e_addr] = wb_e_data;
      if (wb_o_we) model[wb_o_addr] = wb_o_data;
    end
    #1;
    if (sb_q.size() == 0) begin
      check({tag, ".sb_empty"}, 128'd0, 128'd1);
    end else begin
      e = sb_q.pop_front();
      check({tag, ".op"},  {117'b0, op},        {117'b0, e.op});
      check({tag, ".fmt"}, {125'b0, format},    {125'b0, e.fmt});
      check({tag, ".rt"},  {121'b0, rt_addr},   {121'b0, e.rt});
      check({tag, ".imm"}, {110'b0, imm},       {110'b0, e.imm});
      check({tag, ".rw"},  {127'b0, reg_write}, {127'b0, e.rw});
      check({tag, ".ra"},  ra,  e.ra);
      check({tag, ".rb"},  rb,  e.rb);
      check({tag, ".rts"}, rt_st, e.rts);
    end
  endtask

  task automatic set_instr(input logic [10:0] o, input logic [2:0] f,
                           input logic [6:0] a, input logic [6:0] b, input logic [6:0] t,
                           input logic [17:0] im, input logic rw,
                           input logic ua, input logic ub, input logic ut);
    in_valid = 1'b1; in_op = o; in_format = f;
    in_ra_addr = a; in_rb_addr = b; in_rt_addr = t; in_imm = im;
    in_reg_write = rw; in_use_ra = ua; in_use_rb = ub; in_use_rt = ut;
  endtask

  task automatic clear_wb();
    wb_e_we = 1'b0; wb_o_we = 1'b0;
    wb_e_addr = '0; wb_o_addr = '0; wb_e_data = '0; wb_o_data = '0;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) model[i] = 'x;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
    in_op = '0; in_format = '0; in_ra_addr = '0; in_rb_addr = '0; in_rt_addr = '0;
    in_imm = '0; in_reg_write = 1'b0; in_use_ra = 1'b0; in_use_rb = 1'b0; in_use_rt = 1'b0;
    pend_addr = '0; pend_we = '0;
    clear_wb();

    // Reset with an lqx and writebacks to its sources present: all dropped.
    set_instr(OP_LQX, 3'd1, 7'd5, 7'd6, 7'd7, 18'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    wb_e_we = 1'b1; wb_e_addr = 7'd5; wb_e_data = {4{32'h5555_5555}};
    wb_o_we = 1'b1; wb_o_addr = 7'd6; wb_o_data = {4{32'h6666_6666}};
    step("reset");
    reset = 1'b0;
    clear_wb();
    step("post_reset");

    // Populate some registers with no instruction.
    in_valid = 1'b0;
    wb_e_we = 1'b1; wb_e_addr = 7'd12; wb_e_data = {4{32'h1234_5678}};
    wb_o_we = 1'b1; wb_o_addr = 7'd7;  wb_o_data = {4{32'h0777_0777}};
    step("fill");

    // Bypass: odd writes r10 while stqd reads it as store source; even also
    // writes r10 to show the odd port's priority in the bypass.
    set_instr(OP_STQD, 3'd2, 7'd7, 7'd0, 7'd10, 18'h00ABC, 1'b0, 1'b1, 1'b0, 1'b1);
    wb_e_we = 1'b1; wb_e_addr = 7'd10; wb_e_data = {16{8'h11}};
    wb_o_we = 1'b1; wb_o_addr = 7'd10; wb_o_data = {16{8'hAA}};
    step("bypass");
    clear_wb();

    // Hazard on r12 through pend slot 3.
    pend_addr[3] = 7'd12; pend_we[3] = 1'b1;
    set_instr(OP_LQD, 3'd3, 7'd12, 7'd1, 7'd3, 18'h00010, 1'b1, 1'b1, 1'b0, 1'b0);
    step("hazard");
    wb_o_we = 1'b1; wb_o_addr = 7'd12; wb_o_data = {4{32'hBEEF_CAFE}};
    step("hazard_wb");
    clear_wb();
    pend_we[3] = 1'b0;
    step("hazard_clear");

    // Flush coinciding with a hazard on a valid stqa.
    pend_we[3] = 1'b1;
    set_instr(OP_STQA, 3'd4, 7'd0, 7'd0, 7'd12, 18'h3FFFF, 1'b1, 1'b0, 1'b0, 1'b1);
    flush = 1'b1;
    step("flush");
    flush = 1'b0; pend_we = '0;

    // Write conflict on r20, then read it; unused rb matches a pend entry.
    in_valid = 1'b0;
    wb_e_we = 1'b1; wb_e_addr = 7'd20; wb_e_data = 128'd1;
    wb_o_we = 1'b1; wb_o_addr = 7'd20; wb_o_data = 128'd2;
    step("conflict_wr");
    clear_wb();
    pend_addr[0] = 7'd21; pend_we[0] = 1'b1;
    set_instr(OP_LQX, 3'd1, 7'd20, 7'd21, 7'd22, 18'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    step("conflict_rd");
    pend_we = '0;

    // Randomized traffic over a small address window for frequent collisions.
    for (int n = 0; n < 80; n++) begin
      reset = ($urandom_range(0, 19) == 0);
      flush = ($urandom_range(0, 7) == 0);
      set_instr(11'($urandom), 3'($urandom), 7'($urandom_range(0, 15)),
                7'($urandom_range(0, 15)), 7'($urandom_range(0, 15)), 18'($urandom),
                1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      in_valid = ($urandom_range(0, 3) != 0);
      wb_e_we = 1'($urandom); wb_e_addr = 7'($urandom_range(0, 15));
      wb_e_data = {$urandom, $urandom, $urandom, $urandom};
      wb_o_we = 1'($urandom); wb_o_addr = 7'($urandom_range(0, 15));
      wb_o_data = {$urandom, $urandom, $urandom, $urandom};
      for (int i = 0; i < 6; i++) pend_addr[i] = 7'($urandom_range(0, 15));
      pend_we = 6'($urandom) & 6'($urandom);
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/odd_rf_fwd.md
# odd_rf_fwd

Register-fetch/forwarding stage for the odd pipe. It owns the 128 x 128-bit register file, reads operands for one decoded instruction per cycle, bypasses same-cycle writebacks, and detects read-after-write hazards against results still in flight. It registers the operands and control fields into the interface consumed directly by the local-store stage: op, format, rt_addr, ra, rb, rt_st, imm and reg_write.

## Interface
- NUM_REGS, 128, register file depth; addresses are 7 bits.
- WIDTH, 128, register width.
- DEPTH, 6, number of in-flight result stages checked for hazards.

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  decoded instruction present
- in_op  in  [0:10]  decoded opcode
- in_format  in  [2:0]  instruction format
- in_ra_addr, in_rb_addr, in_rt_addr  in  [0:6] each  source A, source B, destination/store-source address
- in_imm  in  [0:17]  immediate
- in_reg_write  in  1  instruction writes rt
- in_use_ra, in_use_rb, in_use_rt  in  1 each  source is actually read; in_use_rt marks a store
- flush  in  1  branch taken; kill the instruction being registered
- wb_e_data / wb_e_addr / wb_e_we  in  WIDTH / [0:6] / 1  even-pipe writeback
- wb_o_data / wb_o_addr / wb_o_we  in  WIDTH / [0:6] / 1  odd-pipe writeback
- pend_addr  in  [DEPTH-1:0][0:6]  destination addresses of in-flight results
- pend_we  in  [DEPTH-1:0]  in-flight result will be written
- op, format, rt_addr, imm, reg_write  out  as inputs  registered control to the local store
- ra, rb, rt_st  out  WIDTH each  registered operand values
- stall  out  1  combinational; upstream must hold its instruction

## Operation
- **Register file write.** Writes occur at posedge from both writeback ports. If both ports target the same address in the same cycle, the odd port wins.
- **Read.** Reads are combinational.
- **Write bypass.** If a read address matches a writeback port with we=1 in the same cycle, the read returns that port's data instead of the array contents. When both ports match, odd has priority.
- **Hazard.** For each source whose in_use_* is 1, a hazard exists if there is any i < DEPTH with pend_we[i]=1 and pend_addr[i] equal to the source address.
  - stall = in_valid & hazard & ~flush.
  - A hazard is not cleared by a writeback in the same cycle; the matching pend entry retires first.
- **Output register load (every cycle, not under reset):**
  - reset: load nop.
  - flush=1: load nop.
  - in_valid=0: load nop.
  - stall=1: load nop (bubble).
  - Otherwise: load in_* fields, with ra/rb/rt_st taken from the bypassed reads of in_ra_addr/in_rb_addr/in_rt_addr.
- **Nop.** op=0, format=0, rt_addr=0, imm=0, reg_write=0, ra=rb=rt_st=0.
- **Unused sources.** Operands for sources with in_use_*=0 are still driven from the read, and they never cause a stall.
- **Flush vs. stall.** When flush=1 and a hazard coincide, flush wins and stall=0.

## Timing
- Latency is 1 cycle: an instruction presented at edge N appears on the outputs after edge N.
- Throughput is 1 instruction per cycle when there is no hazard.
- stall is valid in the same cycle as in_valid. Upstream holds all in_* fields unchanged while stall=1.
- A write at edge N is visible to a read in cycle N via the bypass, and visible from the array thereafter.
- **Reset values.** While reset=1 at a posedge:
  - All outputs are cleared to the nop values.
  - Every register file entry is cleared to 0 in that single edge.
  - stall is forced to 0.
- **Reset mid-stream.** Any held instruction is discarded, and writebacks presented during the reset cycle are dropped.

## Structure
- Shared package (spu_pkg) holds:
  - REG_ADDR_W=7
  - WIDTH=128
  - NOP_OP=11'b0
  - NOP_FORMAT=3'd0
  - the decoded-instruction struct (op, format, addresses, imm, reg_write, use flags)
- One sub-module, register_file: 2 write ports (odd priority), 3 combinational read ports with write bypass, and synchronous clear on reset.
- Hazard compare and the output pipeline register stay in odd_rf_fwd.

## Test plan
- **Reset.** Assert reset for 1 cycle, then present lqx with ra_addr=5 and rb_addr=6 -> outputs nop during reset, and ra=0, rb=0 one cycle after.
- **Bypass.** wb_o writes r10=0xAA..AA in the same cycle that stqd reads in_rt_addr=10 -> rt_st=0xAA..AA next cycle, and stall=0.
- **Hazard.** pend_addr[3]=12 with pend_we[3]=1, and lqd with ra_addr=12 -> stall=1 and outputs nop. Clear pend_we[3] -> the instruction issues next cycle with the current r12 value.
- **Flush.** flush=1 together with a valid stqa -> outputs nop, reg_write=0, stall=0.
- **Write conflict.** wb_e and wb_o both write r20 (e=1, o=2) -> a later read of r20 returns 2. With in_use_rb=0 and rb_addr matching a pend entry -> no stall.
